// File: rtl/data_memory_responder.sv
// data_memory_responder: on-chip word RAM serving drisc core loads/stores.
// Store data is steered into byte lanes here; loads return the whole aligned word.
module data_memory_responder #(
    parameter int          WORD_ADDRESS_WIDTH = 10,
    parameter logic [31:0] BASE_ADDRESS       = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_bus,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_size,
    input  logic        write,
    input  logic        read,
    output logic [31:0] data_out,
    output logic        selected,
    output logic        fault
);
    localparam int          DEPTH        = 1 << WORD_ADDRESS_WIDTH;
    localparam logic [32:0] REGION_BYTES = 33'd4 << WORD_ADDRESS_WIDTH;

    logic [31:0]                   r_mem [0:DEPTH-1];
    logic [31:0]                   r_data_out;
    logic                          r_selected;
    logic                          r_fault;
    logic [31:0]                   w_rel;
    logic                          w_hit;
    logic [WORD_ADDRESS_WIDTH-1:0] w_index;
    logic [1:0]                    w_offset;
    logic                          w_aligned;
    logic [3:0]                    w_be_base;
    logic [3:0]                    w_be;
    logic [31:0]                   w_lane;
    logic                          w_store;
    logic                          w_load;
    logic                          w_fault_set;

    // Addresses below the base wrap to huge offsets and therefore miss.
    assign w_rel    = address_bus - BASE_ADDRESS;
    assign w_hit    = {1'b0, w_rel} < REGION_BYTES;
    assign w_index  = w_rel[WORD_ADDRESS_WIDTH+1:2];
    assign w_offset = address_bus[1:0];

    always_comb begin
        w_aligned = (data_size == 2'b00) ||
                    (data_size == 2'b01 && !w_offset[0]) ||
                    (data_size == 2'b10 && w_offset == 2'b00);
        w_be_base = data_size == 2'b00 ? 4'b0001 : data_size == 2'b01 ? 4'b0011 : 4'b1111;
        w_be      = w_be_base << w_offset;
        w_lane    = data_size == 2'b00 ? {4{data_in[7:0]}} :
                    data_size == 2'b01 ? {2{data_in[15:0]}} : data_in;
    end

    assign w_store     = !reset && write && !read && w_hit && w_aligned;
    assign w_load      = read && !write;
    assign w_fault_set = w_hit && (read || write) && ((read && write) || !w_aligned);

    // No reset on the array so it maps onto block RAM with byte enables.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++)
            if (w_store && w_be[b])
                r_mem[w_index][8*b +: 8] <= w_lane[8*b +: 8];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out <= '0;
            r_selected <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            if (w_load)
                r_data_out <= w_hit ? r_mem[w_index] : '0;
            if (read || write)
                r_selected <= w_hit;
            if (w_fault_set)
                r_fault <= 1'b1;
        end
    end

    assign data_out = r_data_out;
    assign selected = r_selected;
    assign fault    = r_fault;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: byte-level reference model compared every cycle,
// plus hand-computed literal checks along the directed sequence.
module tb_data_memory_responder;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          SIZE = 4096;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address_bus = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  data_size = 2'b10;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] data_out;
    logic        selected;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    bit [7:0]    mm [0:SIZE-1];
    bit          mk [0:SIZE-1];
    logic [31:0] m_dout = '0;
    bit   [3:0]  m_dk = '0;
    bit          m_sel, m_fault, m_valid;

    data_memory_responder dut (
        .clock(clock), .reset(reset), .address_bus(address_bus), .data_in(data_in),
        .data_size(data_size), .write(write), .read(read),
        .data_out(data_out), .selected(selected), .fault(fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Little-endian byte memory: a store of n bytes writes bytes off..off+n-1.
    task automatic model_step(input bit rst, input bit w, input bit r, input logic [31:0] a,
                              input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] off;
        bit hit, al;
        int nb;
        if (rst) begin
            m_dout = '0; m_dk = 4'hF; m_sel = 0; m_fault = 0;
            return;
        end
        off = a - BASE;
        hit = off < SIZE;
        nb  = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : sz == 2'd2 ? 4 : 0;
        al  = nb != 0 && (int'(a[1:0]) % nb) == 0;
        if (w || r) m_sel = hit;
        if (hit) begin
            if (w && r) m_fault = 1;
            else if (w) begin
                if (al) for (int k = 0; k < nb; k++) begin
                    mm[off + k] = d[8*k +: 8];
                    mk[off + k] = 1;
                end else m_fault = 1;
            end else if (r) begin
                if (!al) m_fault = 1;
                for (int k = 0; k < 4; k++) begin
                    m_dout[8*k +: 8] = mm[(off & ~32'd3) + k];
                    m_dk[k]          = mk[(off & ~32'd3) + k];
                end
            end
        end else if (r && !w) begin
            m_dout = '0; m_dk = 4'hF;
        end
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            logic [31:0] mask;
            for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{m_dk[k]}};
            check("model selected", {31'b0, selected}, {31'b0, m_sel});
            check("model fault", {31'b0, fault}, {31'b0, m_fault});
            check("model data_out", data_out & mask, m_dout & mask);
        end
    end

    task automatic cyc(input bit rst, input bit w, input bit r, input logic [31:0] a,
                       input logic [1:0] sz = 2'd2, input logic [31:0] d = 32'h0);
        reset = rst; write = w; read = r; address_bus = a; data_size = sz; data_in = d;
        @(posedge clock);
        #1;
        model_step(rst, w, r, a, sz, d);
    endtask

    initial begin
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        m_valid = 1;
        check("reset data_out", data_out, 32'h0);
        check("reset selected", {31'b0, selected}, 32'h0);
        check("reset fault", {31'b0, fault}, 32'h0);

        cyc(0, 1, 0, 32'h10, 2, 32'hDEAD_BEEF);
        cyc(0, 0, 1, 32'h10);
        check("word load", data_out, 32'hDEAD_BEEF);
        check("word selected", {31'b0, selected}, 32'h1);
        check("word fault", {31'b0, fault}, 32'h0);

        cyc(0, 1, 0, 32'h20, 0, 32'hFFFF_FF11);
        cyc(0, 1, 0, 32'h21, 0, 32'hFFFF_FF22);
        cyc(0, 1, 0, 32'h22, 0, 32'hFFFF_FF33);
        cyc(0, 1, 0, 32'h23, 0, 32'hFFFF_FF44);
        cyc(0, 0, 1, 32'h20);
        check("byte lanes", data_out, 32'h4433_2211);

        cyc(0, 1, 0, 32'h30, 2, 32'hAAAA_AAAA);
        cyc(0, 1, 0, 32'h32, 1, 32'hFFFF_1234);
        cyc(0, 0, 1, 32'h30);
        check("half lane", data_out, 32'h1234_AAAA);
        check("half fault clear", {31'b0, fault}, 32'h0);
        cyc(0, 1, 0, 32'h33, 1, 32'hFFFF_5678);
        check("misaligned store fault", {31'b0, fault}, 32'h1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h30);
        check("misaligned store no write", data_out, 32'h1234_AAAA);
        check("fault sticky", {31'b0, fault}, 32'h1);
        cyc(0, 0, 1, 32'h22, 1);
        check("half read whole word", data_out, 32'h4433_2211);

        cyc(1, 0, 0, 0);
        check("fault cleared by reset", {31'b0, fault}, 32'h0);
        cyc(0, 1, 0, 32'h0, 2, 32'h0102_0304);
        cyc(0, 0, 1, 32'h0);
        check("word 0", data_out, 32'h0102_0304);
        cyc(0, 0, 1, 32'h1000);
        check("miss data_out", data_out, 32'h0);
        check("miss selected", {31'b0, selected}, 32'h0);
        check("miss fault", {31'b0, fault}, 32'h0);
        cyc(0, 1, 0, 32'h1000, 2, 32'h5555_5555);
        cyc(0, 0, 1, 32'h0);
        check("no alias", data_out, 32'h0102_0304);
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        check("wrap miss", data_out, 32'h0);

        cyc(0, 1, 0, 32'h40, 2, 32'hCAFE_BABE);
        cyc(0, 0, 1, 32'h40);
        cyc(0, 1, 1, 32'h40, 2, 32'h0);
        check("rw holds data_out", data_out, 32'hCAFE_BABE);
        check("rw fault", {31'b0, fault}, 32'h1);
        cyc(0, 0, 1, 32'h40);
        check("rw no write", data_out, 32'hCAFE_BABE);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 32'h50, 2, 32'h1234_5678);
        cyc(0, 0, 1, 32'h50);
        cyc(1, 1, 0, 32'h50, 2, 32'hFFFF_FFFF);
        check("reset w/ write data_out", data_out, 32'h0);
        check("reset w/ write selected", {31'b0, selected}, 32'h0);
        cyc(0, 0, 1, 32'h50);
        check("reset blocks write", data_out, 32'h1234_5678);

        cyc(0, 0, 1, 32'h12, 2);
        check("misaligned read data", data_out, 32'hDEAD_BEEF);
        check("misaligned read fault", {31'b0, fault}, 32'h1);

        cyc(0, 1, 0, 32'h60, 0, 32'h0000_0077);
        cyc(0, 1, 0, 32'h60, 0, 32'h0000_0077);
        cyc(0, 0, 1, 32'h60);
        check("repeated store", {24'h0, data_out[7:0]}, 32'h77);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Bus responder for the drisc core's memory interface: decodes `address_bus`, `data_size`, `read`, `write` from the core and serves them from an on-chip word-organised RAM. Places the core's right-aligned store data into the correct byte lanes and returns full aligned words on loads; the core's input buffer does lane extraction and sign extension. Sits beside the core in the system top level, one instance per RAM region; outputs of non-selected instances read as zero so several responders can be OR-combined onto `data_bus_in`.

## Interface
- `WORD_ADDRESS_WIDTH`, 10, number of word-address bits; capacity = 4·2^WORD_ADDRESS_WIDTH bytes (default 4 KiB).
- `BASE_ADDRESS`, 32'h0000_0000, byte address of word 0; must be aligned to the region size.

- `clock`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `address_bus`  in  32  byte address from core.
- `data_in`  in  32  store data from core (`data_bus_out`), value right-aligned in bits [7:0]/[15:0]/[31:0].
- `data_size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `write`  in  1  store request, sampled every rising edge.
- `read`  in  1  load request, sampled every rising edge.
- `data_out`  out  32  aligned load word (to core `data_bus_in`).
- `selected`  out  1  registered: last accepted request hit this region.
- `fault`  out  1  sticky access-fault flag.

## Operation
- Hit = (address_bus − BASE_ADDRESS) < 4·2^WORD_ADDRESS_WIDTH; word index = (address_bus − BASE_ADDRESS)[WORD_ADDRESS_WIDTH+1:2]; offset = address_bus[1:0].
- Aligned: byte any offset; halfword offset 0 or 2; word offset 0. Size 11 is never aligned.
- Request decode per cycle, priority order:
  - `write` and `read` both high: no RAM update, `data_out` holds, `fault` set if hit.
  - `write` only, hit, aligned: byte enables = 0001/0011/1111 shifted left by offset; lane data = `data_in` replicated (byte ×4, half ×2, word ×1); only enabled lanes update.
  - `write` only, hit, misaligned or size 11: no RAM update, `fault` set.
  - `read` only, hit: `data_out` ← full stored word at word index (offset ignored, misalignment not checked — core extracts lanes); misaligned read also sets `fault`.
  - `read` only, miss: `data_out` ← 0.
  - neither: `data_out` holds.
  - Any miss: no RAM update, `fault` unchanged.
- `selected` ← hit when `read` or `write` high; holds otherwise.
- `fault` stays 1 until `reset`.
- RAM contents not initialised and not cleared by reset; implementation infers block RAM with per-byte write enables.

## Timing
- Reset (synchronous): `data_out` = 0, `selected` = 0, `fault` = 0 at the edge where `reset` is high; requests presented in that cycle are ignored (no RAM write, even if `write` high).
- Store: committed at the rising edge where `write` is sampled high; single cycle, no wait states.
- Load latency: 1 cycle — `data_out` valid after the rising edge sampling `read`, held until the next accepted read, miss read or reset. Core samples it in its following phase.
- Load immediately after store to same word (back-to-back cycles) returns the updated word.
- `write` held high over multiple cycles = repeated identical stores (idempotent).
- Address wrap: addresses below BASE_ADDRESS wrap in the unsigned subtraction and are misses.

## Test plan
- Reset, then word store 32'hDEAD_BEEF to 0x0000_0010, read 0x10 next cycle -> `data_out` = 32'hDEAD_BEEF one cycle later, `selected` = 1, `fault` = 0.
- Byte stores 0x11 at 0x20, 0x22 at 0x21, 0x33 at 0x22, 0x44 at 0x23 (data_in upper bits junk 0xFFFFFF__) -> read 0x20 returns 32'h4433_2211.
- Word 0xAAAA_AAAA at 0x30, halfword 0x1234 at 0x32 -> read returns 32'h1234_AAAA; halfword at 0x33 -> RAM unchanged, `fault` = 1, stays 1 until reset.
- Read 0x0000_1000 with default parameters -> `data_out` = 0, `selected` = 0, `fault` unchanged; write there -> no aliasing into word 0.
- `read` and `write` both high at 0x40 -> word unchanged, `data_out` holds previous value, `fault` = 1.
- Assert `reset` with `write` high at 0x50 -> outputs 0, word at 0x50 keeps prior contents.
